// File: rtl/bp_fe_lce_resp_arb.sv
// Merges request-side and command-side LCE responses into one registered ready/valid output.
// Starvation guard: the cmd source is forced to win after starve_limit_p lost arbitrations.
module bp_fe_lce_resp_arb #(
   parameter int unsigned resp_width_p   = 64,
   parameter int unsigned starve_limit_p = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [resp_width_p-1:0] req_resp_i,
   input  logic                    req_resp_v_i,
   output logic                    req_resp_yumi_o,
   input  logic [resp_width_p-1:0] cmd_resp_i,
   input  logic                    cmd_resp_v_i,
   output logic                    cmd_resp_yumi_o,
   output logic [resp_width_p-1:0] lce_resp_o,
   output logic                    lce_resp_v_o,
   input  logic                    lce_resp_ready_i,
   output logic                    starve_override_o
);

   typedef enum logic {E_REQ_PRIO, E_CMD_PRIO} prio_e;

   localparam logic [3:0] StarveLimit = 4'(starve_limit_p);

   prio_e                   state_r, state_n;
   logic [3:0]              starve_cnt_r, starve_cnt_n;
   logic                    valid_r;
   logic [resp_width_p-1:0] data_r;
   logic                    open;
   logic                    grant_req, grant_cmd;

   always_comb begin
      grant_req = 1'b0;
      grant_cmd = 1'b0;
      case (state_r)
         E_REQ_PRIO: begin
            if (req_resp_v_i)      grant_req = 1'b1;
            else if (cmd_resp_v_i) grant_cmd = 1'b1;
         end
         E_CMD_PRIO: begin
            if (cmd_resp_v_i)      grant_cmd = 1'b1;
            else if (req_resp_v_i) grant_req = 1'b1;
         end
         default: ;
      endcase

      // Output slot is free if empty or being drained this cycle.
      open            = ~valid_r | lce_resp_ready_i;
      req_resp_yumi_o = reset_i & open & grant_req;
      cmd_resp_yumi_o = reset_i & open & grant_cmd;

      // Stalled cycles (no yumi) do not count as lost arbitrations.
      starve_cnt_n = starve_cnt_r;
      if (cmd_resp_yumi_o || !cmd_resp_v_i) begin
         starve_cnt_n = '0;
      end else if (req_resp_yumi_o) begin
         starve_cnt_n = (starve_cnt_r >= StarveLimit) ? StarveLimit : starve_cnt_r + 4'd1;
      end

      state_n = state_r;
      case (state_r)
         E_REQ_PRIO: if (starve_cnt_n == StarveLimit) state_n = E_CMD_PRIO;
         E_CMD_PRIO: if (cmd_resp_yumi_o || !cmd_resp_v_i) state_n = E_REQ_PRIO;
         default:    state_n = E_REQ_PRIO;
      endcase

      lce_resp_v_o      = valid_r;
      lce_resp_o        = data_r;
      starve_override_o = (state_r == E_CMD_PRIO);
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_r      <= E_REQ_PRIO;
         starve_cnt_r <= '0;
         valid_r      <= 1'b0;
         data_r       <= '0;
      end else begin
         state_r      <= state_n;
         starve_cnt_r <= starve_cnt_n;
         if (req_resp_yumi_o) begin
            valid_r <= 1'b1;
            data_r  <= req_resp_i;
         end else if (cmd_resp_yumi_o) begin
            valid_r <= 1'b1;
            data_r  <= cmd_resp_i;
         end else if (lce_resp_ready_i) begin
            valid_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bp_fe_lce_resp_arb.sv
// Directed bench for bp_fe_lce_resp_arb: reset, throughput, starvation override,
// backpressure, cmd-only traffic, abandoned override and asynchronous reset.
module tb_bp_fe_lce_resp_arb;

   localparam int unsigned W = 64;

   logic         clk = 1'b0;
   logic         reset_i;
   logic [W-1:0] req_resp_i, cmd_resp_i;
   logic         req_resp_v_i, cmd_resp_v_i;
   logic         req_resp_yumi_o, cmd_resp_yumi_o;
   logic [W-1:0] lce_resp_o;
   logic         lce_resp_v_o;
   logic         lce_resp_ready_i;
   logic         starve_override_o;

   int passed = 0;
   int total  = 0;

   bp_fe_lce_resp_arb #(
      .resp_width_p  (W),
      .starve_limit_p(4)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .req_resp_i       (req_resp_i),
      .req_resp_v_i     (req_resp_v_i),
      .req_resp_yumi_o  (req_resp_yumi_o),
      .cmd_resp_i       (cmd_resp_i),
      .cmd_resp_v_i     (cmd_resp_v_i),
      .cmd_resp_yumi_o  (cmd_resp_yumi_o),
      .lce_resp_o       (lce_resp_o),
      .lce_resp_v_o     (lce_resp_v_o),
      .lce_resp_ready_i (lce_resp_ready_i),
      .starve_override_o(starve_override_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_i = 1'b0; req_resp_v_i = 1'b0; cmd_resp_v_i = 1'b0; lce_resp_ready_i = 1'b0;
      req_resp_i = '0; cmd_resp_i = '0;

      // Reset state, with both sources requesting
      #2; req_resp_v_i = 1'b1; cmd_resp_v_i = 1'b1; #1;
      chk("rst_v", W'(lce_resp_v_o), 0);
      chk("rst_data", lce_resp_o, 0);
      chk("rst_ovr", W'(starve_override_o), 0);
      chk("rst_req_yumi", W'(req_resp_yumi_o), 0);
      chk("rst_cmd_yumi", W'(cmd_resp_yumi_o), 0);
      tick(); tick();
      chk("rst_v_held", W'(lce_resp_v_o), 0);
      req_resp_v_i = 1'b0; cmd_resp_v_i = 1'b0;
      #2; reset_i = 1'b1;
      tick();

      // Req only: 1-cycle latency, one beat per cycle
      req_resp_v_i = 1'b1; req_resp_i = 'hA5; lce_resp_ready_i = 1'b1; #1;
      chk("req_only_yumi", W'(req_resp_yumi_o), 1);
      chk("req_only_cmd_yumi", W'(cmd_resp_yumi_o), 0);
      chk("req_only_v_before", W'(lce_resp_v_o), 0);
      tick();
      chk("req_only_v", W'(lce_resp_v_o), 1);
      chk("req_only_data", lce_resp_o, 'hA5);
      req_resp_i = 'hA6; #1;
      chk("req_only_yumi2", W'(req_resp_yumi_o), 1);
      tick();
      chk("req_only_v2", W'(lce_resp_v_o), 1);
      chk("req_only_data2", lce_resp_o, 'hA6);

      // Both valid: req wins 4, cmd forced on the 5th, repeating
      cmd_resp_v_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         logic exp_cmd;
         exp_cmd    = (i % 5 == 4);
         req_resp_i = W'(32'h100 + i);
         cmd_resp_i = W'(32'h200 + i);
         #1;
         chk($sformatf("fair_req_yumi[%0d]", i), W'(req_resp_yumi_o), W'(!exp_cmd));
         chk($sformatf("fair_cmd_yumi[%0d]", i), W'(cmd_resp_yumi_o), W'(exp_cmd));
         chk($sformatf("fair_ovr[%0d]", i), W'(starve_override_o), W'(exp_cmd));
         tick();
         chk($sformatf("fair_data[%0d]", i), lce_resp_o,
             exp_cmd ? W'(32'h200 + i) : W'(32'h100 + i));
      end

      // Backpressure: two req wins (count 2), then stall 10 cycles
      cmd_resp_i = 'h400;
      req_resp_i = 'h300; tick();
      req_resp_i = 'h301; tick();
      chk("bp_cnt_pre", W'(dut.starve_cnt_r), 2);
      lce_resp_ready_i = 1'b0; req_resp_i = 'h302;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("bp_req_yumi[%0d]", i), W'(req_resp_yumi_o), 0);
         chk($sformatf("bp_cmd_yumi[%0d]", i), W'(cmd_resp_yumi_o), 0);
         tick();
         chk($sformatf("bp_data[%0d]", i), lce_resp_o, 'h301);
         chk($sformatf("bp_cnt[%0d]", i), W'(dut.starve_cnt_r), 2);
      end
      chk("bp_v", W'(lce_resp_v_o), 1);
      lce_resp_ready_i = 1'b1; #1;
      chk("bp_release_yumi", W'(req_resp_yumi_o), 1);
      tick();
      chk("bp_release_data", lce_resp_o, 'h302);
      chk("bp_release_v", W'(lce_resp_v_o), 1);
      chk("bp_release_cnt", W'(dut.starve_cnt_r), 3);
      chk("bp_release_ovr", W'(starve_override_o), 0);
      req_resp_i = 'h303; tick();
      chk("sat_ovr", W'(starve_override_o), 1);
      chk("sat_cnt", W'(dut.starve_cnt_r), 4);
      chk("sat_data", lce_resp_o, 'h303);

      // Override abandoned: cmd drops while forced
      cmd_resp_v_i = 1'b0; req_resp_i = 'h304; #1;
      chk("abandon_req_yumi", W'(req_resp_yumi_o), 1);
      chk("abandon_ovr_now", W'(starve_override_o), 1);
      tick();
      chk("abandon_ovr", W'(starve_override_o), 0);
      chk("abandon_cnt", W'(dut.starve_cnt_r), 0);
      chk("abandon_data", lce_resp_o, 'h304);

      // Cmd only in E_REQ_PRIO
      req_resp_v_i = 1'b0; cmd_resp_v_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cmd_resp_i = W'(32'h500 + i);
         #1;
         chk($sformatf("cmd_only_yumi[%0d]", i), W'(cmd_resp_yumi_o), 1);
         chk($sformatf("cmd_only_req_yumi[%0d]", i), W'(req_resp_yumi_o), 0);
         tick();
         chk($sformatf("cmd_only_data[%0d]", i), lce_resp_o, W'(32'h500 + i));
         chk($sformatf("cmd_only_cnt[%0d]", i), W'(dut.starve_cnt_r), 0);
         chk($sformatf("cmd_only_ovr[%0d]", i), W'(starve_override_o), 0);
      end

      // Dequeue without enqueue empties the slot
      cmd_resp_v_i = 1'b0; tick();
      chk("drain_v", W'(lce_resp_v_o), 0);

      // Async reset between edges with a held response
      req_resp_v_i = 1'b1; req_resp_i = 'h600; lce_resp_ready_i = 1'b0; tick();
      chk("ar_v_pre", W'(lce_resp_v_o), 1);
      chk("ar_data_pre", lce_resp_o, 'h600);
      #2; reset_i = 1'b0; #1;
      chk("ar_v", W'(lce_resp_v_o), 0);
      chk("ar_data", lce_resp_o, 0);
      chk("ar_req_yumi", W'(req_resp_yumi_o), 0);
      tick();
      chk("ar_v_edge", W'(lce_resp_v_o), 0);
      chk("ar_req_yumi_edge", W'(req_resp_yumi_o), 0);
      #2; reset_i = 1'b1; cmd_resp_v_i = 1'b1; req_resp_i = 'h601; cmd_resp_i = 'h700; #1;
      chk("post_rst_req_yumi", W'(req_resp_yumi_o), 1);
      chk("post_rst_cmd_yumi", W'(cmd_resp_yumi_o), 0);
      chk("post_rst_ovr", W'(starve_override_o), 0);
      tick();
      chk("post_rst_data", lce_resp_o, 'h601);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
